// File: rtl/tim_apb_arbiter_if.sv
// Signal bundle between the two requesters, the shared response channel
// and the timer APB slave port of tim_apb_arbiter.
interface tim_apb_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [STRB_W-1:0] req0_strb;
    logic              req0_ready;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [STRB_W-1:0] req1_strb;
    logic              req1_ready;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] tim_paddr;
    logic              tim_psel;
    logic              tim_penable;
    logic              tim_pwrite;
    logic [DATA_W-1:0] tim_pwdata;
    logic [STRB_W-1:0] tim_pstrb;
    logic [DATA_W-1:0] tim_prdata;
    logic              tim_pready;
    logic              tim_pslverr;

    // Arbiter side: takes requests, drives responses and the APB master port.
    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
        output req0_ready,
        input  req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err,
        output tim_paddr, tim_psel, tim_penable, tim_pwrite, tim_pwdata, tim_pstrb,
        input  tim_prdata, tim_pready, tim_pslverr
    );

    // Environment side: requesters, response consumer and the APB slave.
    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
        input  req0_ready,
        output req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
        input  tim_paddr, tim_psel, tim_penable, tim_pwrite, tim_pwdata, tim_pstrb,
        output tim_prdata, tim_pready, tim_pslverr
    );
endinterface

// File: rtl/tim_apb_arbiter.sv
// Round-robin two-requester APB4 master in front of timer_top, with a
// wait-state watchdog that aborts transfers to a hung slave.
module tim_apb_arbiter #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    tim_apb_arbiter_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rr_ptr;
    logic              cur_id;
    logic [CNT_W-1:0]  wait_cnt;

    logic              grant;
    logic              grant_vld;
    logic              accept;
    logic              done;
    logic              abort;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_strb;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the watchdog fires at the end of the TIMEOUT-th ACCESS cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.tim_pready || (wait_cnt == CNT_W'(TIMEOUT - 1))) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant selection, accept handshake and completion decode
    always_comb begin
        grant     = rr_ptr;
        grant_vld = 1'b0;
        if (rr_ptr ? bus.req1_valid : bus.req0_valid) begin
            grant     = rr_ptr;
            grant_vld = 1'b1;
        end else if (rr_ptr ? bus.req0_valid : bus.req1_valid) begin
            grant     = ~rr_ptr;
            grant_vld = 1'b1;
        end

        accept         = (state == IDLE) && grant_vld;
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;

        sel_write = grant ? bus.req1_write : bus.req0_write;
        sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
        sel_strb  = grant ? bus.req1_strb  : bus.req0_strb;

        done  = (state == ACCESS) && bus.tim_pready;
        abort = (state == ACCESS) && !bus.tim_pready && (wait_cnt == CNT_W'(TIMEOUT - 1));
    end

    // APB master registers, round-robin pointer, watchdog and response channel
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.tim_paddr   <= '0;
            bus.tim_psel    <= 1'b0;
            bus.tim_penable <= 1'b0;
            bus.tim_pwrite  <= 1'b0;
            bus.tim_pwdata  <= '0;
            bus.tim_pstrb   <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            rr_ptr          <= 1'b0;
            cur_id          <= 1'b0;
            wait_cnt        <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;

            if (accept) begin
                bus.tim_paddr  <= sel_addr;
                bus.tim_pwrite <= sel_write;
                bus.tim_pwdata <= sel_wdata;
                bus.tim_pstrb  <= sel_write ? sel_strb : '0;
                bus.tim_psel   <= 1'b1;
                cur_id         <= grant;
                rr_ptr         <= ~grant;
                wait_cnt       <= '0;
            end

            if (state == SETUP) begin
                bus.tim_penable <= 1'b1;
            end

            if ((state == ACCESS) && !bus.tim_pready && !abort) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            // Abort reports as an error with no data
            if (done || abort) begin
                bus.tim_psel    <= 1'b0;
                bus.tim_penable <= 1'b0;
                bus.rsp_valid   <= 1'b1;
                bus.rsp_id      <= cur_id;
                bus.rsp_err     <= done ? bus.tim_pslverr : 1'b1;
                bus.rsp_rdata   <= (done && !bus.tim_pwrite) ? bus.tim_prdata : '0;
            end
        end
    end
endmodule

// File: doc/tim_apb_arbiter.md
# tim_apb_arbiter

Two-port APB4 master arbiter sitting in front of `timer_top`.
- It accepts single register-access requests from two independent requesters: requester 0 (CPU bridge) and requester 1 (config/DMA loader).
- It grants them round-robin and runs one APB transfer at a time on the timer's APB slave port.
- It returns read data and error status on a shared response channel.
- A wait-state watchdog stops a hung slave from locking the bus.

## Interface
- `ADDR_W`, 12, APB address width.
- `DATA_W`, 32, APB data width; strobe width is `DATA_W/8`.
- `TIMEOUT`, 16, maximum ACCESS cycles with `tim_pready` low before abort; must be ≥1.
- `sys_clk` in 1: system clock; all flops rise-edge.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `reqN_valid` in 1 (N=0,1): request pending; held with its fields until accepted.
- `reqN_write` in 1: 1 = write, 0 = read.
- `reqN_addr` in ADDR_W: register address.
- `reqN_wdata` in DATA_W: write data.
- `reqN_strb` in DATA_W/8: write byte strobes.
- `reqN_ready` out 1: combinational accept; the request is taken on the edge where `valid && ready`.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_id` out 1: requester the response belongs to.
- `rsp_rdata` out DATA_W: read data; 0 for writes and aborts.
- `rsp_err` out 1: `tim_pslverr` sampled at completion, or timeout abort.
- `tim_paddr` out ADDR_W, `tim_psel` out 1, `tim_penable` out 1, `tim_pwrite` out 1, `tim_pwdata` out DATA_W, `tim_pstrb` out DATA_W/8: APB master outputs, all registered.
- `tim_prdata` in DATA_W, `tim_pready` in 1, `tim_pslverr` in 1: APB slave responses.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. The reset state is IDLE.
- **IDLE**
  - `reqN_ready` = (state==IDLE) && (grant==N).
  - `grant` = the requester named by the round-robin pointer if it is valid, otherwise the other requester if it is valid.
  - On acceptance: latch addr, write, wdata and strb into the APB output registers, record `cur_id`, and go to SETUP.
  - `tim_pstrb` is forced to 0 for reads.
- **SETUP** (exactly 1 cycle): `psel`=1, `penable`=0; go to ACCESS.
- **ACCESS**: `psel`=1, `penable`=1.
  - If `tim_pready`=1: sample `prdata` (reads only) and `pslverr`, pulse `rsp_valid`, drop `psel`/`penable`, go to IDLE.
  - If `tim_pready`=0: increment the wait counter.
- **Timeout**: `tim_pready` still low at the end of the TIMEOUT-th ACCESS cycle means abort. Return `rsp_err`=1 and `rsp_rdata`=0, drop `psel`/`penable`, go to IDLE.
- The wait counter is `$clog2(TIMEOUT+1)` bits and clears on entry to SETUP.
- **Round-robin**: after a grant to N, the pointer moves to 1−N. Reset pointer = 0, so req0 wins the first simultaneous request.
- Address, data, strobe and write stay stable from SETUP through the end of ACCESS, whatever the requester inputs do.
- Requests that arrive while the FSM is not in IDLE wait, with `ready`=0; none are dropped or queued internally.

## Timing
- **Reset**: every output is 0. `rsp_*`=0 and `tim_*`=0 (`paddr`, `pwdata`, `pstrb` all zero). FSM = IDLE, pointer = 0, wait counter = 0.
- **Zero-wait transfer**: accept at edge E0, SETUP during E0–E1, ACCESS during E1–E2. `pready` is sampled high at E2, so `rsp_valid` is high during E2–E3.
- **Latency and throughput**: latency from acceptance to response is 2 cycles plus wait states. The next acceptance can happen at edge E3, giving 3 cycles per transfer back-to-back.
- `rsp_valid` with `rsp_id`, `rsp_rdata` and `rsp_err` is valid for exactly one cycle. `rsp_rdata` and `rsp_err` hold their last value otherwise; only `rsp_valid` is qualifying.
- **Abort timing**: with `pready` stuck low, `rsp_valid` (err=1) rises TIMEOUT+1 cycles after the SETUP edge.
- **Reset asserted mid-transfer**: outputs clear immediately and asynchronously. No response is produced for the in-flight request; the requester reissues it.
- `tim_pready` and `tim_pslverr` are ignored outside ACCESS.

## Test plan
- **Reset**: reset asserted mid-ACCESS → `tim_psel`=`penable`=0 with no clock. After release, `rsp_valid` never pulses for the lost request.
- **Single write**: req0 write, addr 12'h000, wdata 32'h0000_0001, strb 4'hF, `pready` tied 1 → one SETUP cycle then one ACCESS cycle with those values on the bus. Then `rsp_valid`=1, `rsp_id`=0, `rsp_err`=0, exactly 2 cycles after acceptance.
- **Read with wait states**: req1 read, addr 12'h004, slave returns `pready` after 3 low cycles with `prdata` 32'hDEAD_BEEF → `tim_pstrb`=0 and `rsp_rdata`=32'hDEAD_BEEF, `rsp_id`=1. `paddr` stays stable across all ACCESS cycles.
- **Simultaneous requests**: both valid continuously from reset, 4 transfers → grant order 0,1,0,1. Only one `reqN_ready` is high in any cycle, and the responses carry matching `rsp_id`.
- **Slave error**: `pslverr`=1 with `pready`=1 on a write to 12'hFFC → `rsp_err`=1, `rsp_rdata`=0, and the FSM returns to IDLE.
- **Timeout**: TIMEOUT=4, `pready` held 0 → exactly 4 ACCESS cycles, then `psel` drops and `rsp_err`=1. The next queued request starts normally.
